// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states and framing constants.
// Intended for reuse by a future receiver as well as the sender.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;
  localparam int unsigned UART_DATA_BITS       = 8;

endpackage

// File: rtl/baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick on the last cycle of each period.
// Held at zero while clear is high so the first period after clear is always full length.
module baud_counter #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned CNT_W        = 16
) (
  input  logic CLK,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = ~clear & (cnt_q == LastCnt);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_sender.sv
// 8N1 UART transmitter fed byte-wise by the word-to-byte sender buffer over valid/sender_ready.
// All outputs are registered; ARM inserts one non-accepting ready cycle so stale data is skipped.
module uart_sender
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic [UART_DATA_BITS-1:0] data,
  input  logic                      valid,
  output logic                      sender_ready,
  output logic                      txd,
  output logic                      busy
);

  localparam logic [2:0] LastBit = 3'(UART_DATA_BITS - 1);

  uart_tx_state_t            state_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic [2:0]                bit_idx_q;
  logic                      txd_q;
  logic                      ready_q;
  logic                      busy_q;
  logic                      cnt_clear;
  logic                      bit_tick;

  // The baud counter only runs while a frame is on the line.
  assign cnt_clear = (state_q == IDLE) || (state_q == ARM);

  baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_baud_counter (
    .CLK   (CLK),
    .reset (reset),
    .clear (cnt_clear),
    .tick  (bit_tick)
  );

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q   <= ARM;
      shift_q   <= '0;
      bit_idx_q <= '0;
      txd_q     <= 1'b1;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      unique case (state_q)
        ARM: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        IDLE: begin
          if (valid) begin
            shift_q <= data;
            state_q <= START;
            txd_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (bit_tick) begin
            state_q   <= DATA;
            bit_idx_q <= '0;
            txd_q     <= shift_q[0];
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (bit_idx_q == LastBit) begin
              state_q <= STOP;
              txd_q   <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              txd_q     <= shift_q[bit_idx_q + 3'd1];
            end
          end
        end
        STOP: begin
          // Ready rises on entry to ARM, one cycle before an accept is possible.
          if (bit_tick) begin
            state_q <= ARM;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ARM;
          txd_q   <= 1'b1;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sender_ready = ready_q;
  assign txd          = txd_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_uart_sender.sv
// Randomized scoreboard bench for uart_sender at 4, 2 and 868 clocks per bit.
// Stimulus predicts each accept cycle from the handshake rules; a line monitor decodes frames.
module tb_uart_sender;

  typedef struct {
    logic [7:0] b;
    int         acc;
    bit         abort;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data;
  logic       valid;
  int         sel;
  logic [2:0] vld, rdy, tx, bsy;
  logic       rdy_s, tx_s, bsy_s;
  int         cpb;
  int         cyc = 0;
  int         checks = 0;
  int         passed = 0;
  int         earliest = 0;
  int         last_acc = 0;
  exp_t       sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign vld[0] = valid && (sel == 0);
  assign vld[1] = valid && (sel == 1);
  assign vld[2] = valid && (sel == 2);
  assign rdy_s  = rdy[sel[1:0]];
  assign tx_s   = tx[sel[1:0]];
  assign bsy_s  = bsy[sel[1:0]];

  always_comb begin
    case (sel)
      0:       cpb = 4;
      1:       cpb = 2;
      default: cpb = 868;
    endcase
  end

  uart_sender #(.CLKS_PER_BIT(4), .CNT_W(16)) u_dut4 (
    .CLK (clk), .reset (rst_n), .data (data), .valid (vld[0]),
    .sender_ready (rdy[0]), .txd (tx[0]), .busy (bsy[0])
  );

  uart_sender #(.CLKS_PER_BIT(2), .CNT_W(16)) u_dut2 (
    .CLK (clk), .reset (rst_n), .data (data), .valid (vld[1]),
    .sender_ready (rdy[1]), .txd (tx[1]), .busy (bsy[1])
  );

  uart_sender #(.CLKS_PER_BIT(868), .CNT_W(16)) u_dut868 (
    .CLK (clk), .reset (rst_n), .data (data), .valid (vld[2]),
    .sender_ready (rdy[2]), .txd (tx[2]), .busy (bsy[2])
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d, sel %0d)", name, act, exp, cyc, sel);
  endtask

  // Called at a negedge. Accept lands on the first edge that is both after now and no earlier
  // than the model's next IDLE edge; returns at the negedge just after that accept.
  task automatic send(input logic [7:0] b, input bit hold, input bit abort = 1'b0);
    int a;
    data  = b;
    valid = 1'b1;
    a = (cyc + 1 > earliest) ? cyc + 1 : earliest;
    sb.push_back('{b, a, abort});
    while (cyc < a - 1) @(negedge clk);
    check("ready_before_accept", rdy_s, 1);
    @(negedge clk);
    last_acc = a;
    earliest = a + 10 * cpb + 2;
    if (!hold) begin
      valid = 1'b0;
      data  = 8'($urandom);
    end
  endtask

  task automatic wait_idle();
    while (cyc < earliest) @(negedge clk);
  endtask

  task automatic reset_pulse(input int new_sel);
    @(negedge clk);
    rst_n = 1'b0;
    valid = 1'b0;
    sel   = new_sel;
    repeat (2) @(negedge clk);
    check("ready_in_reset", rdy_s, 0);
    rst_n    = 1'b1;
    earliest = cyc + 2;
    @(negedge clk);
  endtask

  // Line monitor: decodes each frame from txd and compares against the scoreboard.
  initial begin
    bit         prev;
    int         st, n;
    exp_t       e;
    logic [9:0] lv;
    bit         glitch, flag, aborted;
    logic [7:0] got;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && prev && !tx_s) begin
        st = cyc;
        n = cpb;
        glitch = 1'b0;
        flag = 1'b0;
        aborted = 1'b0;
        lv = '1;
        if (sb.size() == 0) begin
          check("spurious_frame", 1, 0);
          e = '{8'h00, st, 1'b0};
        end else begin
          e = sb.pop_front();
        end
        check("start_latency", st, e.acc);
        for (int i = 0; i < 10 * n; i++) begin
          if (i > 0) @(negedge clk);
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          if (i % n == 0) lv[i / n] = tx_s;
          else if (tx_s !== lv[i / n]) glitch = 1'b1;
          if (bsy_s !== 1'b1 || rdy_s !== 1'b0) flag = 1'b1;
        end
        if (aborted) begin
          check("abort_expected", e.abort, 1);
        end else begin
          check("bit_width_stable", glitch, 0);
          check("busy_ready_in_frame", flag, 0);
          check("start_bit", lv[0], 0);
          check("stop_bit", lv[9], 1);
          got = lv[8:1];
          check("data_byte", got, e.b);
          @(negedge clk);
          check("ready_after_frame", rdy_s, 1);
          check("busy_after_frame", bsy_s, 0);
          check("txd_idle_after_frame", tx_s, 1);
        end
      end
      prev = rst_n ? tx_s : 1'b1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    sel   = 0;
    rst_n = 1'b0;
    valid = 1'b0;
    data  = 8'h00;
    repeat (3) begin
      @(negedge clk);
      check("reset_txd", tx_s, 1);
      check("reset_ready", rdy_s, 0);
      check("reset_busy", bsy_s, 0);
    end
    // valid already high at release: the first edge must not accept.
    data     = 8'h5A;
    valid    = 1'b1;
    rst_n    = 1'b1;
    earliest = cyc + 2;
    @(negedge clk);
    check("ready_after_release", rdy_s, 1);
    send(8'h5A, 1'b0);

    // Single-cycle valid pulse.
    while (cyc + 1 < earliest) @(negedge clk);
    send(8'hA5, 1'b0);

    // Buffer-style handshake: next byte presented right after each accept.
    send(8'h12, 1'b1);
    send(8'h34, 1'b1);
    send(8'h56, 1'b1);
    send(8'h78, 1'b0);

    // Stale data guard: identical byte with valid held across two windows.
    send(8'h3C, 1'b1);
    send(8'h3C, 1'b0);

    for (int k = 0; k < 12; k++) begin
      repeat ($urandom_range(0, 12)) @(negedge clk);
      send(8'($urandom), 1'($urandom_range(0, 1)));
    end
    valid = 1'b0;
    wait_idle();

    // Reset during data bit 3 of 8'hFF.
    send(8'hFF, 1'b0, 1'b1);
    while (cyc < last_acc + 4 * cpb + 1) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("txd_async_reset", tx_s, 1);
    check("busy_async_reset", bsy_s, 0);
    repeat (2) @(negedge clk);
    check("ready_in_reset_mid", rdy_s, 0);
    data     = 8'h00;
    valid    = 1'b1;
    rst_n    = 1'b1;
    earliest = cyc + 2;
    @(negedge clk);
    check("ready_after_release2", rdy_s, 1);
    send(8'h00, 1'b0);
    wait_idle();

    reset_pulse(1);
    send(8'($urandom), 1'b0);
    send(8'($urandom), 1'b0);
    wait_idle();

    reset_pulse(2);
    send(8'($urandom), 1'b0);
    wait_idle();

    @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uart_sender.md
Name: uart_sender

Overview:
- Serial transmit stage directly downstream of the 32-bit word-to-byte sender buffer.
- Consumes one byte per handshake on `valid`/`sender_ready` and shifts it out on a single TX line as 8N1 UART: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
- Drives `sender_ready` back to the buffer so it can pace its four bytes per word.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200 baud); legal range 2..65535.
- CNT_W, 16, width of the baud counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset), released synchronously by the board logic.
- data  input  8  byte to transmit (the buffer's `output_data`).
- valid  input  1  `data` is offered for transmission.
- sender_ready  output  1  high when a byte can be accepted.
- txd  output  1  serial line; idle high.
- busy  output  1  high from accept until the end of the stop bit.

Behaviour:
- Reset values while `reset` = 0: `txd` = 1, `sender_ready` = 0, `busy` = 0, state = ARM, baud counter = 0, bit index = 0, shift register = 0.
- Reset mid-frame aborts the frame immediately (asynchronously): `txd` = 1, no partial stop bit.
- States:
  - IDLE: `sender_ready` = 1. Accept on a rising edge with `valid` = 1: latch `data` into the shift register, go to START, counter = 0.
  - ARM: `sender_ready` = 1, `busy` = 0, no accept regardless of `valid`. Lasts exactly 1 cycle, then IDLE. Purpose: the buffer loads its next byte in response to `sender_ready` rising, so `data` held from the previous handshake is never re-accepted.
  - START: `txd` = 0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: `txd` = shift[bit index] for CLKS_PER_BIT cycles per bit. After bit index 7 completes, go to STOP.
  - STOP: `txd` = 1 for CLKS_PER_BIT cycles, then ARM.
- `sender_ready` is 0 in START/DATA/STOP. `busy` is 1 in START/DATA/STOP.
- Timing:
  - Accept-to-first-txd-low latency: 1 cycle. `txd` is registered.
  - Full frame: exactly 10*CLKS_PER_BIT cycles of line activity.
  - Minimum byte-to-byte spacing: 10*CLKS_PER_BIT + 2 cycles (ARM + IDLE accept).
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1. The bit-end tick is counter == CLKS_PER_BIT-1; the counter then wraps to 0.
  - No cumulative drift: each bit is exactly CLKS_PER_BIT cycles.
- `data` changing during a frame has no effect; the shift register holds the accepted byte.
- `valid` dropping during a frame is ignored. `valid` held high continuously sends one byte per handshake window, accepted only in IDLE.
- Reset release: ARM for 1 cycle, then IDLE. The first byte can be accepted on the 2nd rising edge after release.

Decomposition:
- Shared package `uart_pkg`: typedef enum `uart_tx_state_t` {IDLE, ARM, START, DATA, STOP}, localparam DEFAULT_CLKS_PER_BIT = 868, localparam UART_DATA_BITS = 8.
- The same package is to be reused by a future receiver.
- One sub-module: `baud_counter`.
  - Parameters CLKS_PER_BIT, CNT_W.
  - Inputs CLK, reset, clear.
  - Output `tick`, pulsing on the last cycle of each bit period.
  - The FSM, shift register and bit index stay in `uart_sender`.

Test Plan (CLKS_PER_BIT = 4 unless stated):
- Reset → `reset` = 0 for 3 cycles, then release → `txd` = 1 and `sender_ready` = 0 during reset; `sender_ready` = 1 from the 1st edge after release; no accept on that edge.
- Single byte → `data` = 8'hA5 with `valid` pulsed 1 cycle in IDLE → `txd` sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles; `txd` low 1 cycle after accept; `sender_ready` back to 1 after 40 cycles.
- Buffer handshake → drive with the existing byte buffer for word 32'h12345678 → line bytes 8'h12, 8'h34, 8'h56, 8'h78 in order; no byte duplicated or dropped; `valid` low after the 4th accept.
- Stale data guard → hold `valid` = 1 and `data` = 8'h3C constant across two frames → exactly one frame per IDLE window; the ARM cycle never accepts; 2nd frame starts exactly 2 cycles after the 1st stop bit ends.
- Reset mid-frame → assert `reset` = 0 during data bit 3 of 8'hFF → `txd` = 1 within the same cycle; after release, ARM then IDLE; the next byte 8'h00 is sent complete and correct.
- Baud boundary → CLKS_PER_BIT = 2 and CLKS_PER_BIT = 868 → frame length exactly 20 and 8680 cycles; stop bit full length; no off-by-one at counter wrap.
